// File: rtl/mano_bus_load_ctrl_pkg.sv
// Shared timing, ALU opcode and instruction-field definitions for the
// basic-computer bus load controller.
package mano_bus_load_ctrl_pkg;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6,
    T7 = 3'd7
  } tstate_e;

  typedef enum logic [2:0] {
    ALU_NONE = 3'd0,
    ALU_AND  = 3'd1,
    ALU_ADD  = 3'd2,
    ALU_LDA  = 3'd3,
    ALU_CMA  = 3'd4,
    ALU_CIR  = 3'd5,
    ALU_CIL  = 3'd6,
    ALU_RSVD = 3'd7
  } alu_op_e;

  localparam int unsigned D_AND = 0;
  localparam int unsigned D_ADD = 1;
  localparam int unsigned D_LDA = 2;
  localparam int unsigned D_STA = 3;
  localparam int unsigned D_BUN = 4;
  localparam int unsigned D_BSA = 5;
  localparam int unsigned D_ISZ = 6;
  localparam int unsigned D_IOR = 7;

  localparam int unsigned RR_CLA = 11;
  localparam int unsigned RR_CLE = 10;
  localparam int unsigned RR_CMA = 9;
  localparam int unsigned RR_CME = 8;
  localparam int unsigned RR_CIR = 7;
  localparam int unsigned RR_CIL = 6;
  localparam int unsigned RR_INC = 5;
  localparam int unsigned RR_SPA = 4;
  localparam int unsigned RR_SNA = 3;
  localparam int unsigned RR_SZA = 2;
  localparam int unsigned RR_SZE = 1;
  localparam int unsigned RR_HLT = 0;

  function automatic logic [7:0] decode_d(input logic [2:0] opcode);
    return 8'b0000_0001 << opcode;
  endfunction

endpackage

// File: rtl/mano_seq_counter.sv
// 3-bit sequence counter SC: increments while enabled, returns to 0 on clr,
// holds while the run flip-flop is off.
module mano_seq_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  output logic [2:0] sc
);

  logic [2:0] sc_d, sc_q;

  always_comb begin
    sc_d = sc_q;
    if (en) begin
      sc_d = clr ? '0 : sc_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q <= '0;
    end else begin
      sc_q <= sc_d;
    end
  end

  assign sc = sc_q;

endmodule

// File: rtl/mano_bus_load_ctrl.sv
// Destination-side controller for the basic-computer common bus: owns SC, I
// and S, and decodes every register strobe and the ALU opcode per timing state.
module mano_bus_load_ctrl
  import mano_bus_load_ctrl_pkg::*;
#(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] ir,
  input  logic          ac_msb,
  input  logic          ac_zero,
  input  logic          dr_zero,
  input  logic          e_val,
  output logic [2:0]    t,
  output logic          running,
  output logic          i_flag,
  output logic          ar_ld,
  output logic          ar_inr,
  output logic          pc_ld,
  output logic          pc_inr,
  output logic          dr_ld,
  output logic          dr_inr,
  output logic          ac_ld,
  output logic          ac_inr,
  output logic          ac_clr,
  output logic          ir_ld,
  output logic          mem_wr,
  output logic          e_clr,
  output logic          e_cmp,
  output logic [2:0]    alu_op,
  output logic          sc_clr
);

  logic          s_d, s_q;
  logic          i_d, i_q;
  logic [2:0]    sc;
  tstate_e       t_st;
  alu_op_e       alu_sel;
  logic [7:0]    d;
  logic [AW-1:0] rr;

  mano_seq_counter u_sc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (s_q),
    .clr   (sc_clr),
    .sc    (sc)
  );

  assign t_st = tstate_e'(sc);
  assign d    = decode_d(ir[DW-2 -: 3]);
  assign rr   = ir[AW-1:0];

  always_comb begin
    s_d     = s_q;
    i_d     = i_q;
    ar_ld   = 1'b0;
    ar_inr  = 1'b0;
    pc_ld   = 1'b0;
    pc_inr  = 1'b0;
    dr_ld   = 1'b0;
    dr_inr  = 1'b0;
    ac_ld   = 1'b0;
    ac_inr  = 1'b0;
    ac_clr  = 1'b0;
    ir_ld   = 1'b0;
    mem_wr  = 1'b0;
    e_clr   = 1'b0;
    e_cmp   = 1'b0;
    sc_clr  = 1'b0;
    alu_sel = ALU_NONE;

    if (!s_q) begin
      if (start) s_d = 1'b1;
    end else begin
      unique case (t_st)
        T0: ar_ld = 1'b1;
        T1: begin
          ir_ld  = 1'b1;
          pc_inr = 1'b1;
        end
        T2: begin
          ar_ld = 1'b1;
          i_d   = ir[DW-1];
        end
        T3: begin
          if (!d[D_IOR]) begin
            ar_ld = i_q;
          end else begin
            sc_clr = 1'b1;
            if (!i_q) begin
              // Only one AC action per cycle: CLA > CMA > CIR > CIL > INC.
              if (rr[RR_CLA]) begin
                ac_clr = 1'b1;
              end else if (rr[RR_CMA]) begin
                ac_ld   = 1'b1;
                alu_sel = ALU_CMA;
              end else if (rr[RR_CIR]) begin
                ac_ld   = 1'b1;
                alu_sel = ALU_CIR;
              end else if (rr[RR_CIL]) begin
                ac_ld   = 1'b1;
                alu_sel = ALU_CIL;
              end else if (rr[RR_INC]) begin
                ac_inr = 1'b1;
              end
              e_clr  = rr[RR_CLE];
              e_cmp  = rr[RR_CME];
              pc_inr = (rr[RR_SPA] & ~ac_msb) | (rr[RR_SNA] & ac_msb) |
                       (rr[RR_SZA] & ac_zero) | (rr[RR_SZE] & ~e_val);
              if (rr[RR_HLT]) s_d = 1'b0;
            end
          end
        end
        T4: begin
          if (d[D_AND] | d[D_ADD] | d[D_LDA] | d[D_ISZ]) begin
            dr_ld = 1'b1;
          end else if (d[D_STA]) begin
            mem_wr = 1'b1;
            sc_clr = 1'b1;
          end else if (d[D_BUN]) begin
            pc_ld  = 1'b1;
            sc_clr = 1'b1;
          end else if (d[D_BSA]) begin
            mem_wr = 1'b1;
            ar_inr = 1'b1;
          end else begin
            sc_clr = 1'b1;
          end
        end
        T5: begin
          if (d[D_AND] | d[D_ADD] | d[D_LDA]) begin
            ac_ld   = 1'b1;
            alu_sel = d[D_AND] ? ALU_AND : (d[D_ADD] ? ALU_ADD : ALU_LDA);
            sc_clr  = 1'b1;
          end else if (d[D_BSA]) begin
            pc_ld  = 1'b1;
            sc_clr = 1'b1;
          end else if (d[D_ISZ]) begin
            dr_inr = 1'b1;
          end else begin
            sc_clr = 1'b1;
          end
        end
        T6: begin
          sc_clr = 1'b1;
          if (d[D_ISZ]) begin
            mem_wr = 1'b1;
            pc_inr = dr_zero;
          end
        end
        default: sc_clr = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= 1'b0;
      i_q <= 1'b0;
    end else begin
      s_q <= s_d;
      i_q <= i_d;
    end
  end

  assign t       = sc;
  assign running = s_q;
  assign i_flag  = i_q;
  assign alu_op  = alu_sel;

endmodule

// File: tb/tb_mano_bus_load_ctrl.sv
// Self-checking bench for mano_bus_load_ctrl: per-cycle vector table with a
// scoreboard of expected output words, plus a mid-instruction reset sequence.
module tb_mano_bus_load_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] ir = '0;
  logic        ac_msb = 1'b0, ac_zero = 1'b0, dr_zero = 1'b0, e_val = 1'b0;
  logic [2:0]  t, alu_op;
  logic        running, i_flag, ar_ld, ar_inr, pc_ld, pc_inr, dr_ld, dr_inr;
  logic        ac_ld, ac_inr, ac_clr, ir_ld, mem_wr, e_clr, e_cmp, sc_clr;

  mano_bus_load_ctrl #(.AW(12), .DW(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ir(ir),
    .ac_msb(ac_msb), .ac_zero(ac_zero), .dr_zero(dr_zero), .e_val(e_val),
    .t(t), .running(running), .i_flag(i_flag),
    .ar_ld(ar_ld), .ar_inr(ar_inr), .pc_ld(pc_ld), .pc_inr(pc_inr),
    .dr_ld(dr_ld), .dr_inr(dr_inr), .ac_ld(ac_ld), .ac_inr(ac_inr),
    .ac_clr(ac_clr), .ir_ld(ir_ld), .mem_wr(mem_wr), .e_clr(e_clr),
    .e_cmp(e_cmp), .alu_op(alu_op), .sc_clr(sc_clr)
  );

  always #5 clk = ~clk;

  localparam logic [12:0] S_AR_LD  = 13'h1000;
  localparam logic [12:0] S_AR_INR = 13'h0800;
  localparam logic [12:0] S_PC_LD  = 13'h0400;
  localparam logic [12:0] S_PC_INR = 13'h0200;
  localparam logic [12:0] S_DR_LD  = 13'h0100;
  localparam logic [12:0] S_DR_INR = 13'h0080;
  localparam logic [12:0] S_AC_LD  = 13'h0040;
  localparam logic [12:0] S_AC_INR = 13'h0020;
  localparam logic [12:0] S_AC_CLR = 13'h0010;
  localparam logic [12:0] S_IR_LD  = 13'h0008;
  localparam logic [12:0] S_MEM_WR = 13'h0004;
  localparam logic [12:0] S_E_CLR  = 13'h0002;
  localparam logic [12:0] S_E_CMP  = 13'h0001;

  // Output word: {t, running, i_flag, 13 strobes, alu_op, sc_clr}
  logic [21:0] act;
  assign act = {t, running, i_flag, ar_ld, ar_inr, pc_ld, pc_inr, dr_ld, dr_inr,
                ac_ld, ac_inr, ac_clr, ir_ld, mem_wr, e_clr, e_cmp, alu_op, sc_clr};

  typedef struct {
    string       name;
    logic        st;
    logic [15:0] irv;
    logic [3:0]  stat;   // {dr_zero, ac_msb, ac_zero, e_val}
    logic [21:0] exp_v;
  } vec_t;

  vec_t        tbl[$];
  logic [21:0] sb[$];
  int          errors = 0;
  int          checks = 0;

  function automatic logic [21:0] mk(input logic [2:0] tv, input logic run, input logic iv,
                                     input logic [12:0] s, input logic [2:0] alu,
                                     input logic scc);
    return {tv, run, iv, s, alu, scc};
  endfunction

  function automatic void add(input string nm, input logic st, input logic [15:0] irv,
                              input logic [3:0] stat, input logic [21:0] e);
    vec_t v;
    v.name = nm; v.st = st; v.irv = irv; v.stat = stat; v.exp_v = e;
    tbl.push_back(v);
  endfunction

  function automatic void fetch(input string nm, input logic [15:0] irv,
                                input logic [3:0] stat, input logic iv);
    add({nm, "_t0"}, 1'b0, irv, stat, mk(3'd0, 1'b1, iv, S_AR_LD, 3'd0, 1'b0));
    add({nm, "_t1"}, 1'b0, irv, stat, mk(3'd1, 1'b1, iv, S_IR_LD | S_PC_INR, 3'd0, 1'b0));
    add({nm, "_t2"}, 1'b0, irv, stat, mk(3'd2, 1'b1, iv, S_AR_LD, 3'd0, 1'b0));
  endfunction

  task automatic check(input string nm);
    logic [21:0] e;
    e = sb.pop_front();
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0d run=%0b i=%0b)", nm, act, e,
               t, running, i_flag);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    start = v.st;
    ir = v.irv;
    {dr_zero, ac_msb, ac_zero, e_val} = v.stat;
    sb.push_back(v.exp_v);
    #2;
    check(v.name);
  endtask

  task automatic run_table();
    foreach (tbl[k]) apply(tbl[k]);
    tbl.delete();
  endtask

  initial begin
    // Reset state, with start held high to show it has no effect under reset.
    start = 1'b1;
    #3;
    sb.push_back('0);
    check("reset_state");
    @(posedge clk);
    #2;
    sb.push_back('0);
    check("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;

    add("start", 1'b1, 16'h7800, 4'b0000, mk(3'd0, 1'b0, 1'b0, '0, 3'd0, 1'b0));
    fetch("cla", 16'h7800, 4'b0000, 1'b0);
    add("cla_t3", 1'b0, 16'h7800, 4'b0000, mk(3'd3, 1'b1, 1'b0, S_AC_CLR, 3'd0, 1'b1));

    fetch("add_d", 16'h1123, 4'b0000, 1'b0);
    add("add_d_t3", 1'b0, 16'h1123, 4'b0000, mk(3'd3, 1'b1, 1'b0, '0, 3'd0, 1'b0));
    add("add_d_t4", 1'b0, 16'h1123, 4'b0000, mk(3'd4, 1'b1, 1'b0, S_DR_LD, 3'd0, 1'b0));
    add("add_d_t5", 1'b0, 16'h1123, 4'b0000, mk(3'd5, 1'b1, 1'b0, S_AC_LD, 3'd2, 1'b1));

    fetch("add_i", 16'h9123, 4'b0000, 1'b0);
    add("add_i_t3", 1'b0, 16'h9123, 4'b0000, mk(3'd3, 1'b1, 1'b1, S_AR_LD, 3'd0, 1'b0));
    add("add_i_t4", 1'b0, 16'h9123, 4'b0000, mk(3'd4, 1'b1, 1'b1, S_DR_LD, 3'd0, 1'b0));
    add("add_i_t5", 1'b0, 16'h9123, 4'b0000, mk(3'd5, 1'b1, 1'b1, S_AC_LD, 3'd2, 1'b1));

    fetch("isz_z", 16'h6050, 4'b1000, 1'b1);
    add("isz_z_t3", 1'b0, 16'h6050, 4'b1000, mk(3'd3, 1'b1, 1'b0, '0, 3'd0, 1'b0));
    add("isz_z_t4", 1'b0, 16'h6050, 4'b1000, mk(3'd4, 1'b1, 1'b0, S_DR_LD, 3'd0, 1'b0));
    add("isz_z_t5", 1'b0, 16'h6050, 4'b1000, mk(3'd5, 1'b1, 1'b0, S_DR_INR, 3'd0, 1'b0));
    add("isz_z_t6", 1'b0, 16'h6050, 4'b1000,
        mk(3'd6, 1'b1, 1'b0, S_MEM_WR | S_PC_INR, 3'd0, 1'b1));

    fetch("isz_nz", 16'h6050, 4'b0000, 1'b0);
    add("isz_nz_t3", 1'b0, 16'h6050, 4'b0000, mk(3'd3, 1'b1, 1'b0, '0, 3'd0, 1'b0));
    add("isz_nz_t4", 1'b0, 16'h6050, 4'b0000, mk(3'd4, 1'b1, 1'b0, S_DR_LD, 3'd0, 1'b0));
    add("isz_nz_t5", 1'b0, 16'h6050, 4'b0000, mk(3'd5, 1'b1, 1'b0, S_DR_INR, 3'd0, 1'b0));
    add("isz_nz_t6", 1'b0, 16'h6050, 4'b0000, mk(3'd6, 1'b1, 1'b0, S_MEM_WR, 3'd0, 1'b1));

    // CLE CMA CME CIR INC SPA SZA together: CMA wins AC, single skip.
    fetch("rr1", 16'h77B4, 4'b0011, 1'b0);
    add("rr1_t3", 1'b0, 16'h77B4, 4'b0011,
        mk(3'd3, 1'b1, 1'b0, S_AC_LD | S_PC_INR | S_E_CLR | S_E_CMP, 3'd4, 1'b1));
    // CIL over INC; SNA false with ac_msb=0.
    fetch("rr2", 16'h7068, 4'b0001, 1'b0);
    add("rr2_t3", 1'b0, 16'h7068, 4'b0001, mk(3'd3, 1'b1, 1'b0, S_AC_LD, 3'd6, 1'b1));
    // INC alone, SZE true with e_val=0.
    fetch("rr3", 16'h7022, 4'b0100, 1'b0);
    add("rr3_t3", 1'b0, 16'h7022, 4'b0100,
        mk(3'd3, 1'b1, 1'b0, S_AC_INR | S_PC_INR, 3'd0, 1'b1));

    fetch("io", 16'hF400, 4'b0000, 1'b0);
    add("io_t3", 1'b0, 16'hF400, 4'b0000, mk(3'd3, 1'b1, 1'b1, '0, 3'd0, 1'b1));

    fetch("hlt", 16'h7001, 4'b0000, 1'b1);
    add("hlt_t3", 1'b0, 16'h7001, 4'b0000, mk(3'd3, 1'b1, 1'b0, '0, 3'd0, 1'b1));
    for (int k = 0; k < 3; k++)
      add("halted", 1'b0, 16'h7001, 4'b1111, mk(3'd0, 1'b0, 1'b0, '0, 3'd0, 1'b0));
    add("restart", 1'b1, 16'h5010, 4'b0000, mk(3'd0, 1'b0, 1'b0, '0, 3'd0, 1'b0));

    fetch("bsa", 16'h5010, 4'b0000, 1'b0);
    add("bsa_t3", 1'b0, 16'h5010, 4'b0000, mk(3'd3, 1'b1, 1'b0, '0, 3'd0, 1'b0));
    add("bsa_t4", 1'b0, 16'h5010, 4'b0000,
        mk(3'd4, 1'b1, 1'b0, S_MEM_WR | S_AR_INR, 3'd0, 1'b0));
    add("bsa_t5", 1'b0, 16'h5010, 4'b0000, mk(3'd5, 1'b1, 1'b0, S_PC_LD, 3'd0, 1'b1));
    run_table();

    // BSA interrupted by reset during T4.
    fetch("bsa_r", 16'h5010, 4'b0000, 1'b0);
    add("bsa_r_t3", 1'b0, 16'h5010, 4'b0000, mk(3'd3, 1'b1, 1'b0, '0, 3'd0, 1'b0));
    add("bsa_r_t4", 1'b0, 16'h5010, 4'b0000,
        mk(3'd4, 1'b1, 1'b0, S_MEM_WR | S_AR_INR, 3'd0, 1'b0));
    run_table();
    #1;
    rst_n = 1'b0;
    #1;
    sb.push_back('0);
    check("mid_reset_async");
    @(negedge clk);
    sb.push_back('0);
    check("mid_reset_hold");
    rst_n = 1'b1;

    add("restart2", 1'b1, 16'h5010, 4'b0000, mk(3'd0, 1'b0, 1'b0, '0, 3'd0, 1'b0));
    fetch("bsa2", 16'h5010, 4'b0000, 1'b0);
    add("bsa2_t3", 1'b0, 16'h5010, 4'b0000, mk(3'd3, 1'b1, 1'b0, '0, 3'd0, 1'b0));
    add("bsa2_t4", 1'b0, 16'h5010, 4'b0000,
        mk(3'd4, 1'b1, 1'b0, S_MEM_WR | S_AR_INR, 3'd0, 1'b0));
    add("bsa2_t5", 1'b0, 16'h5010, 4'b0000, mk(3'd5, 1'b1, 1'b0, S_PC_LD, 3'd0, 1'b1));
    add("bsa2_next_t0", 1'b0, 16'h5010, 4'b0000, mk(3'd0, 1'b1, 1'b0, S_AR_LD, 3'd0, 1'b0));
    run_table();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mano_bus_load_ctrl.md
Name: mano_bus_load_ctrl

Overview:
- Destination-side controller for the basic-computer common bus.
- Owns the 3-bit sequence counter SC, the I (indirect) flip-flop and the S (run) flip-flop.
- Generates every register load/increment/clear strobe, the memory write strobe and the ALU opcode. These strobes capture whatever the bus-source selector drives in the same timing state.
- Exports t so the bus-source selector shares the same timing.

Parameters:
- AW, 12, address width (AR, PC, IR address field)
- DW, 16, data word width (IR, AC, DR)

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  sets S when S=0; ignored while running
- ir  in  DW  current IR contents
- ac_msb  in  1  AC[15]
- ac_zero  in  1  AC==0
- dr_zero  in  1  DR==0, sampled in ISZ T6
- e_val  in  1  E flip-flop value
- t  out  3  timing state T0..T6 (SC value)
- running  out  1  S flip-flop
- i_flag  out  1  I flip-flop
- ar_ld, ar_inr  out  1  AR strobes
- pc_ld, pc_inr  out  1  PC strobes
- dr_ld, dr_inr  out  1  DR strobes
- ac_ld, ac_inr, ac_clr  out  1  AC strobes
- ir_ld  out  1  IR load
- mem_wr  out  1  write bus value to M[AR]
- e_clr, e_cmp  out  1  E clear and E complement
- alu_op  out  3  0 none, 1 AND, 2 ADD, 3 pass DR, 4 CMA, 5 CIR, 6 CIL, 7 reserved
- sc_clr  out  1  SC returns to T0 on this edge

Behaviour:
- Reset (async, rst_n low): SC=0, I=0, S=0. All strobes are 0, alu_op=0, t=0.
- S=0: all strobes are forced 0 and SC holds. The next edge with start=1 sets S. T0 begins on the following cycle.
- S=1: SC increments each edge, or goes to 0 when sc_clr=1. SC never passes 6; if SC reaches 7, force sc_clr.
- Strobes are combinational from SC, I, ir and the status inputs. They take effect on the edge that ends the state, so latency is zero cycles into the state.
- Decode: D = one-hot of ir[14:12].
- T0: ar_ld (AR<-PC).
- T1: ir_ld, pc_inr.
- T2: ar_ld (AR<-IR[11:0]). I <= ir[15] on this edge.
- T3, D7=0, I=1: ar_ld (indirect, AR<-M[AR]).
- T3, D7=0, I=0: no action.
- T3, D7=1, I=0 (register-ref), always with sc_clr. Each of the following ir bits acts independently:
  - ir[11] CLA: ac_clr.
  - ir[10] CLE: e_clr.
  - ir[9] CMA: ac_ld with alu_op=4.
  - ir[8] CME: e_cmp.
  - ir[7] CIR: ac_ld with alu_op=5.
  - ir[6] CIL: ac_ld with alu_op=6.
  - ir[5] INC: ac_inr.
  - ir[4] SPA: pc_inr if ac_msb=0.
  - ir[3] SNA: pc_inr if ac_msb=1.
  - ir[2] SZA: pc_inr if ac_zero.
  - ir[1] SZE: pc_inr if e_val=0.
  - ir[0] HLT: S<=0.
- AC conflict rule: at most one AC action per cycle, priority CLA > CMA > CIR > CIL > INC.
- Skip rule: any true skip condition gives a single pc_inr.
- T3, D7=1, I=1 (I/O): treated as NOP, sc_clr only.
- AND/ADD/LDA (D0/D1/D2):
  - T4: dr_ld.
  - T5: ac_ld with alu_op 1/2/3 respectively, plus sc_clr.
- STA (D3), T4: mem_wr, sc_clr.
- BUN (D4), T4: pc_ld, sc_clr.
- BSA (D5):
  - T4: mem_wr, ar_inr.
  - T5: pc_ld, sc_clr.
- ISZ (D6):
  - T4: dr_ld.
  - T5: dr_inr.
  - T6: mem_wr, sc_clr, and pc_inr iff dr_zero.
- Strobe exclusivity: no cycle asserts both ld and inr of the same register.
- rst_n asserted mid-instruction: immediate abort to the reset state. The partially executed instruction is not resumed.

Decomposition:
- Shared package holds:
  - T0..T6 constants.
  - ALU_* opcode enum.
  - D-index constants.
  - Register-ref bit positions CLA..HLT.
- One sub-module, mano_seq_counter: SC register with inc/clr and an S-gated enable.
- Decode and strobe logic stay in the top module.

Test Plan:
- Reset, then start=1 with ir=16'h7800 (CLA): S=1, t steps 0->1->2->3. Strobes: ar_ld@T0, ir_ld+pc_inr@T1, ar_ld@T2, ac_clr+sc_clr@T3. t returns to 0.
- ir=16'h1123 (ADD direct): dr_ld@T4, ac_ld with alu_op=2 plus sc_clr@T5. i_flag=0; no ar_ld@T3.
- ir=16'h9123 (ADD indirect): i_flag=1 after T2, ar_ld@T3, then same T4/T5 as the direct case.
- ir=16'h6050 (ISZ) run twice, dr_zero=1 on one run and 0 on the other: T6 gives mem_wr+sc_clr every time; pc_inr only on the dr_zero=1 run.
- ir=16'h7001 (HLT): S clears after T3, running=0, all strobes 0 and t frozen at 0 until start=1.
- ir=16'h5010 (BSA), with rst_n pulsed low during T4: all outputs are immediately 0 and t=0. Restart on start=1 executes from T0.
